// File: rtl/sr_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sr_seq_pkg
// Description : Shared definitions for the SR latch sequencer. Holds the FSM
//               state encoding and a ceiling-log2 helper for sizing the
//               counters and index registers.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package sr_seq_pkg;

    localparam int         c_ST_W      = 2;
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_PULSE  = 2'd1;
    localparam logic [1:0] c_ST_SETTLE = 2'd2;
    localparam logic [1:0] c_ST_CHECK  = 2'd3;

    // Ceiling log2, never below 1 so the result is always a legal width.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sr_latch_sequencer_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin picker. Returns the first eligible
//               requester at or after the pointer, wrapping modulo N.
// Ports       : i_eligible [N]     - one bit per eligible requester
//               i_ptr      [IDX_W] - starting position of the search
//               o_valid            - at least one requester is eligible
//               o_gnt_idx  [IDX_W] - index of the selected requester
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import sr_seq_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = clog2(N)
) (
    input  logic [N-1:0]     i_eligible,
    input  logic [IDX_W-1:0] i_ptr,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_gnt_idx
);

    int w_cand;

    // Scan from the farthest offset back to the pointer so the candidate
    // closest to the pointer is the last writer and therefore wins.
    always_comb begin
        o_valid   = 1'b0;
        o_gnt_idx = '0;
        w_cand    = 0;
        for (int k = N - 1; k >= 0; k--) begin
            w_cand = int'(i_ptr) + k;
            if (w_cand >= N) begin
                w_cand = w_cand - N;
            end
            if (i_eligible[w_cand[IDX_W-1:0]]) begin
                o_valid   = 1'b1;
                o_gnt_idx = w_cand[IDX_W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sr_latch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sr_latch_sequencer
// Description : Sole driver of a NOR SR latch shared by N_REQ clients.
//               Grants set/clear requests round-robin, drives a fixed-width
//               s or r pulse, lets the latch settle, then checks q and acks.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               req_set/req_clr [N] - level requests, held until ack
//               latch_q             - latch output
//               latch_s/latch_r     - registered latch drives (never both 1)
//               ack [N]             - one-hot completion pulse
//               err                 - q mismatch after settle, with ack
//               conflict            - some client requested set and clr
//               busy                - sequencer is not IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module sr_latch_sequencer
    import sr_seq_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int PULSE_CYC  = 2,
    parameter int SETTLE_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req_set,
    input  logic [N_REQ-1:0] req_clr,
    input  logic             latch_q,
    output logic             latch_s,
    output logic             latch_r,
    output logic [N_REQ-1:0] ack,
    output logic             err,
    output logic             conflict,
    output logic             busy
);

    localparam int c_IDX_W = clog2(N_REQ);
    localparam int c_MAXC  = (PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC;
    localparam int c_CNT_W = clog2(c_MAXC + 1);

    logic [c_ST_W-1:0]  r_state, w_state_next;
    logic [c_CNT_W-1:0] r_cnt, w_cnt_next;
    logic [c_IDX_W-1:0] r_gnt_idx, w_gnt_next;
    logic [c_IDX_W-1:0] r_ptr, w_ptr_next;
    logic               r_exp, w_exp_next;
    logic               r_latch_s, r_latch_r, r_err, r_conflict;
    logic [N_REQ-1:0]   r_ack;
    logic [N_REQ-1:0]   w_elig;
    logic               w_arb_valid;
    logic [c_IDX_W-1:0] w_arb_idx;

    // A client asking for both set and clear is simply not eligible.
    assign w_elig = req_set ^ req_clr;

    rr_arbiter #(
        .N     (N_REQ),
        .IDX_W (c_IDX_W)
    ) u_arb (
        .i_eligible (w_elig),
        .i_ptr      (r_ptr),
        .o_valid    (w_arb_valid),
        .o_gnt_idx  (w_arb_idx)
    );

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_gnt_next   = r_gnt_idx;
        w_exp_next   = r_exp;
        w_ptr_next   = r_ptr;
        case (r_state)
            c_ST_IDLE: begin
                if (w_arb_valid) begin
                    w_gnt_next = w_arb_idx;
                    w_exp_next = req_set[w_arb_idx];
                    // Latch already holds the target value: skip the pulse.
                    if (latch_q == w_exp_next) begin
                        w_state_next = c_ST_CHECK;
                    end else begin
                        w_state_next = c_ST_PULSE;
                        w_cnt_next   = c_CNT_W'(PULSE_CYC - 1);
                    end
                end
            end
            c_ST_PULSE: begin
                if (r_cnt == '0) begin
                    w_state_next = c_ST_SETTLE;
                    w_cnt_next   = c_CNT_W'(SETTLE_CYC - 1);
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            c_ST_SETTLE: begin
                if (r_cnt == '0) begin
                    w_state_next = c_ST_CHECK;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            c_ST_CHECK: begin
                w_state_next = c_ST_IDLE;
                w_ptr_next   = (r_gnt_idx == c_IDX_W'(N_REQ - 1)) ? '0 : r_gnt_idx + 1'b1;
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state decode so they line up
    // exactly with the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_cnt      <= '0;
            r_gnt_idx  <= '0;
            r_ptr      <= '0;
            r_exp      <= 1'b0;
            r_latch_s  <= 1'b0;
            r_latch_r  <= 1'b0;
            r_ack      <= '0;
            r_err      <= 1'b0;
            r_conflict <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_gnt_idx  <= w_gnt_next;
            r_ptr      <= w_ptr_next;
            r_exp      <= w_exp_next;
            r_latch_s  <= (w_state_next == c_ST_PULSE) &&  w_exp_next;
            r_latch_r  <= (w_state_next == c_ST_PULSE) && !w_exp_next;
            r_ack      <= (w_state_next == c_ST_CHECK) ? (N_REQ'(1) << w_gnt_next) : '0;
            // Sampled on the edge into CHECK, i.e. after the settle window.
            r_err      <= (w_state_next == c_ST_CHECK) && (latch_q != w_exp_next);
            r_conflict <= (r_state == c_ST_IDLE) && (|(req_set & req_clr));
        end
    end

    assign latch_s  = r_latch_s;
    assign latch_r  = r_latch_r;
    assign ack      = r_ack;
    assign err      = r_err;
    assign conflict = r_conflict;
    assign busy     = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sr_latch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sr_latch_sequencer
// Description : Self-checking bench for sr_latch_sequencer with a behavioural
//               latch model and an expected-ack scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sr_latch_sequencer;

    localparam int P = 2;
    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req_set = '0;
    logic [3:0] req_clr = '0;
    logic       latch_q, latch_s, latch_r, err, conflict, busy;
    logic [3:0] ack;

    logic model_q;
    logic stuck0 = 1'b0;
    logic force_en = 1'b0;
    logic force_val = 1'b0;
    logic monitor_on = 1'b0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int s_hi = 0, r_hi = 0, conf_hi = 0, busy_hi = 0, ack_hi = 0;

    typedef struct {
        logic [3:0] ack;
        logic       err;
        int         due;
    } exp_t;
    exp_t sb[$];

    sr_latch_sequencer #(
        .N_REQ      (4),
        .PULSE_CYC  (P),
        .SETTLE_CYC (S)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_set  (req_set),
        .req_clr  (req_clr),
        .latch_q  (latch_q),
        .latch_s  (latch_s),
        .latch_r  (latch_r),
        .ack      (ack),
        .err      (err),
        .conflict (conflict),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural latch: q follows a lone s or r on the next edge.
    always @(posedge clk) begin
        if (stuck0)                   model_q <= 1'b0;
        else if (force_en)            model_q <= force_val;
        else if (latch_s && !latch_r) model_q <= 1'b1;
        else if (latch_r && !latch_s) model_q <= 1'b0;
    end
    assign latch_q = model_q;

    always @(negedge clk) begin
        if (monitor_on) begin
            checks++;
            if ((latch_s & latch_r) !== 1'b0 || !$onehot0(ack) || (err === 1'b1 && ack == 4'b0)) begin
                failures++;
                $display("FAIL invariant cyc=%0d latch_s=%b latch_r=%b ack=%b err=%b (need s&r=0, ack one-hot, err only with ack)",
                         cyc, latch_s, latch_r, ack, err);
            end
        end
        if (latch_s === 1'b1)  s_hi++;
        if (latch_r === 1'b1)  r_hi++;
        if (conflict === 1'b1) conf_hi++;
        if (busy === 1'b1)     busy_hi++;
        if (ack !== 4'b0)      ack_hi++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic wait_ack(output logic [3:0] o_ack, output logic o_err, output int o_cyc, output bit o_seen);
        o_seen = 1'b0; o_ack = '0; o_err = 1'b0; o_cyc = 0;
        for (int i = 0; i < 40 && !o_seen; i++) begin
            @(negedge clk);
            if (ack !== 4'b0) begin
                o_seen = 1'b1; o_ack = ack; o_err = err; o_cyc = cyc;
            end
        end
    endtask

    task automatic apply_reset;
        @(negedge clk);
        rst = 1'b1; req_set = '0; req_clr = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; force_en = 1'b1; force_val = 1'b0;
        repeat (3) @(negedge clk);
        force_en = 1'b0;
        monitor_on = 1'b1;
        checks++; if (latch_s !== 1'b0)  begin failures++; $display("FAIL reset_latch_s got=%b want=0", latch_s); end
        checks++; if (latch_r !== 1'b0)  begin failures++; $display("FAIL reset_latch_r got=%b want=0", latch_r); end
        checks++; if (ack !== 4'b0)      begin failures++; $display("FAIL reset_ack got=%b want=0000", ack); end
        checks++; if (err !== 1'b0)      begin failures++; $display("FAIL reset_err got=%b want=0", err); end
        checks++; if (conflict !== 1'b0) begin failures++; $display("FAIL reset_conflict got=%b want=0", conflict); end
        checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        rst = 1'b0;
    endtask

    task automatic test_single_set;
        logic [3:0] a; logic e; int c; bit seen; exp_t x; int s0, r0;
        @(negedge clk);
        s0 = s_hi; r0 = r_hi;
        req_set = 4'b0001;
        sb.push_back(exp_t'{ack: 4'b0001, err: 1'b0, due: cyc + 1 + P + S});
        wait_ack(a, e, c, seen);
        req_set = '0;
        x = sb.pop_front();
        checks++;
        if (!seen || a !== x.ack || e !== x.err || c != x.due) begin
            failures++;
            $display("FAIL single_set ack=%b err=%b cyc=%0d seen=%0d want ack=%b err=%b cyc=%0d", a, e, c, seen, x.ack, x.err, x.due);
        end
        checks++; if (s_hi - s0 != P) begin failures++; $display("FAIL single_set_pulse s_cycles=%0d want=%0d", s_hi - s0, P); end
        checks++; if (r_hi != r0)     begin failures++; $display("FAIL single_set_r r_cycles=%0d want=0", r_hi - r0); end
        @(negedge clk);
        checks++; if (model_q !== 1'b1) begin failures++; $display("FAIL single_set_q q=%b want=1", model_q); end
    endtask

    task automatic test_noop;
        logic [3:0] a; logic e; int c; bit seen; exp_t x; int s0, r0;
        @(negedge clk);
        s0 = s_hi; r0 = r_hi;
        req_set = 4'b0100;
        sb.push_back(exp_t'{ack: 4'b0100, err: 1'b0, due: cyc + 1});
        wait_ack(a, e, c, seen);
        req_set = '0;
        x = sb.pop_front();
        checks++;
        if (!seen || a !== x.ack || e !== x.err || c != x.due) begin
            failures++;
            $display("FAIL noop ack=%b err=%b cyc=%0d seen=%0d want ack=%b err=%b cyc=%0d", a, e, c, seen, x.ack, x.err, x.due);
        end
        checks++;
        if (s_hi != s0 || r_hi != r0) begin
            failures++; $display("FAIL noop_pulse s_cycles=%0d r_cycles=%0d want 0 0", s_hi - s0, r_hi - r0);
        end
    endtask

    task automatic test_round_robin;
        logic [3:0] a; logic e; int c; bit seen; exp_t x; int d0;
        apply_reset();
        @(negedge clk);
        req_clr = 4'b1111;
        d0 = cyc + 1 + P + S;
        sb.push_back(exp_t'{ack: 4'b0001, err: 1'b0, due: d0});
        sb.push_back(exp_t'{ack: 4'b0010, err: 1'b0, due: d0 + 2});
        sb.push_back(exp_t'{ack: 4'b0100, err: 1'b0, due: d0 + 4});
        sb.push_back(exp_t'{ack: 4'b1000, err: 1'b0, due: d0 + 6});
        sb.push_back(exp_t'{ack: 4'b0001, err: 1'b0, due: d0 + 8});
        for (int i = 0; i < 5; i++) begin
            wait_ack(a, e, c, seen);
            if (i == 4) req_clr = '0;
            x = sb.pop_front();
            checks++;
            if (!seen || a !== x.ack || e !== x.err || c != x.due) begin
                failures++;
                $display("FAIL round_robin[%0d] ack=%b err=%b cyc=%0d seen=%0d want ack=%b err=%b cyc=%0d",
                         i, a, e, c, seen, x.ack, x.err, x.due);
            end
        end
    endtask

    task automatic test_conflict;
        int c0, a0, s0, r0, b0;
        apply_reset();
        @(negedge clk);
        #1;
        c0 = conf_hi; a0 = ack_hi; s0 = s_hi; r0 = r_hi; b0 = busy_hi;
        req_set = 4'b0010; req_clr = 4'b0010;
        repeat (8) @(negedge clk);
        #1;
        checks++; if (conf_hi - c0 != 8) begin failures++; $display("FAIL conflict_pulses got=%0d want=8", conf_hi - c0); end
        checks++; if (ack_hi != a0)      begin failures++; $display("FAIL conflict_ack got=%0d acks want=0", ack_hi - a0); end
        checks++;
        if (s_hi != s0 || r_hi != r0 || busy_hi != b0) begin
            failures++; $display("FAIL conflict_idle s=%0d r=%0d busy=%0d cycles want 0 0 0", s_hi - s0, r_hi - r0, busy_hi - b0);
        end
        req_set = '0; req_clr = '0;
        repeat (2) @(negedge clk);
        checks++; if (conflict !== 1'b0) begin failures++; $display("FAIL conflict_clear got=%b want=0", conflict); end
    endtask

    task automatic test_stuck_latch;
        logic [3:0] a; logic e; int c; bit seen; exp_t x;
        apply_reset();
        stuck0 = 1'b1;
        @(negedge clk);
        req_set = 4'b1000;
        sb.push_back(exp_t'{ack: 4'b1000, err: 1'b1, due: cyc + 1 + P + S});
        wait_ack(a, e, c, seen);
        req_set = '0;
        x = sb.pop_front();
        checks++;
        if (!seen || a !== x.ack || e !== x.err || c != x.due) begin
            failures++;
            $display("FAIL stuck_latch ack=%b err=%b cyc=%0d seen=%0d want ack=%b err=%b cyc=%0d", a, e, c, seen, x.ack, x.err, x.due);
        end
        stuck0 = 1'b0;
    endtask

    task automatic test_reset_mid_op;
        logic [3:0] a; logic e; int c; bit seen; exp_t x; bit got_r;
        apply_reset();
        // Move the pointer to 3 with a full set by requester 2.
        @(negedge clk);
        req_set = 4'b0100;
        sb.push_back(exp_t'{ack: 4'b0100, err: 1'b0, due: cyc + 1 + P + S});
        wait_ack(a, e, c, seen);
        req_set = '0;
        x = sb.pop_front();
        checks++;
        if (!seen || a !== x.ack || e !== x.err || c != x.due) begin
            failures++;
            $display("FAIL midop_setup ack=%b err=%b cyc=%0d seen=%0d want ack=%b err=%b cyc=%0d", a, e, c, seen, x.ack, x.err, x.due);
        end
        // Start a clear for requester 3 and reset it mid-pulse.
        @(negedge clk);
        req_clr = 4'b1000;
        got_r = 1'b0;
        for (int i = 0; i < 10 && !got_r; i++) begin
            @(negedge clk);
            if (latch_r === 1'b1) got_r = 1'b1;
        end
        checks++; if (!got_r) begin failures++; $display("FAIL midop_pulse latch_r never high want a pulse"); end
        rst = 1'b1;
        req_clr = 4'b1010;
        @(negedge clk);
        checks++; if (latch_r !== 1'b0) begin failures++; $display("FAIL midop_latch_r got=%b want=0", latch_r); end
        checks++; if (busy !== 1'b0)    begin failures++; $display("FAIL midop_busy got=%b want=0", busy); end
        checks++; if (ack !== 4'b0)     begin failures++; $display("FAIL midop_ack got=%b want=0000", ack); end
        rst = 1'b0;
        // Pointer restarts at 0, so requester 1 must win over requester 3.
        sb.push_back(exp_t'{ack: 4'b0010, err: 1'b0, due: -1});
        sb.push_back(exp_t'{ack: 4'b1000, err: 1'b0, due: -1});
        for (int i = 0; i < 2; i++) begin
            wait_ack(a, e, c, seen);
            req_clr = req_clr & ~a;
            x = sb.pop_front();
            checks++;
            if (!seen || a !== x.ack || e !== x.err) begin
                failures++;
                $display("FAIL midop_restart[%0d] ack=%b err=%b seen=%0d want ack=%b err=%b", i, a, e, seen, x.ack, x.err);
            end
        end
        req_clr = '0;
    endtask

    initial begin
        test_reset();
        test_single_set();
        test_noop();
        test_round_robin();
        test_conflict();
        test_stuck_latch();
        test_reset_mid_op();
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
